// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe
// Purpose  : Pipelined execute stage with EX/MEM output register, iterative
//            MUL/DIV unit with HI/LO, and branch/jump target resolution.
//            Optional macro EX_FAST_MUL_EN: single-cycle MULT/MULTU.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_pc,
    input  logic [25:0]       i_imm,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    input  logic              i_alusrc,
    input  logic              i_extop,
    input  logic [4:0]        i_op,
    input  logic              i_jump,
    input  logic              i_beq,
    input  logic              i_bne,
    input  logic              i_ready,
    output logic              o_valid,
    output logic              o_wben,
    output logic [DATA_W-1:0] o_alures,
    output logic [DATA_W-1:0] o_op2,
    output logic [31:0]       o_nextpc,
    output logic              o_pcsrc
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [4:0] c_OP_ADD  = 5'd0,  c_OP_SUB  = 5'd1,  c_OP_AND  = 5'd2;
    localparam logic [4:0] c_OP_OR   = 5'd3,  c_OP_XOR  = 5'd4,  c_OP_NOR  = 5'd5;
    localparam logic [4:0] c_OP_SLT  = 5'd6,  c_OP_SLTU = 5'd7,  c_OP_SLL  = 5'd8;
    localparam logic [4:0] c_OP_SRL  = 5'd9,  c_OP_SRA  = 5'd10, c_OP_LUI  = 5'd11;
    localparam logic [4:0] c_OP_MULT = 5'd12, c_OP_MULTU = 5'd13, c_OP_DIV = 5'd14;
    localparam logic [4:0] c_OP_DIVU = 5'd15, c_OP_MFHI = 5'd16, c_OP_MFLO = 5'd17;
    localparam logic [4:0] c_OP_MTHI = 5'd18, c_OP_MTLO = 5'd19;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_MDU_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [DATA_W-1:0]   r_hi, r_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_opb, r_dividend;
    logic                r_is_div, r_neg_lo, r_neg_hi, r_div0;

    logic [DATA_W-1:0] w_imm_ext, w_opb, w_alu;
    logic [SHAMT_W-1:0] w_shamt;
    logic              w_wben, w_xfer, w_is_mdu, w_mdu_start, w_out_free, w_mdu_commit;
    logic [31:0]       w_pc4, w_btarget, w_jtarget, w_nextpc;
    logic              w_zero, w_pcsrc;

    assign w_imm_ext = i_extop ? {{(DATA_W-16){i_imm[15]}}, i_imm[15:0]}
                               : {{(DATA_W-16){1'b0}}, i_imm[15:0]};
    assign w_opb     = i_alusrc ? w_imm_ext : i_op2;
    assign w_shamt   = i_op1[SHAMT_W-1:0];

    assign w_out_free   = ~o_valid | i_ready;
    assign o_ready      = (r_state == ST_RUN) & w_out_free;
    assign w_xfer       = i_valid & o_ready;
    assign w_is_mdu     = (i_op[4:2] == 3'b011);
    assign w_mdu_commit = (r_state == ST_MDU_DONE) & w_out_free;
`ifdef EX_FAST_MUL_EN
    logic [2*DATA_W-1:0] w_fast_a, w_fast_b, w_fast_prod;
    assign w_fast_a    = i_op[0] ? {{DATA_W{1'b0}}, i_op1} : {{DATA_W{i_op1[DATA_W-1]}}, i_op1};
    assign w_fast_b    = i_op[0] ? {{DATA_W{1'b0}}, i_op2} : {{DATA_W{i_op2[DATA_W-1]}}, i_op2};
    assign w_fast_prod = w_fast_a * w_fast_b;
    assign w_mdu_start = w_xfer & w_is_mdu & i_op[1];
`else
    assign w_mdu_start = w_xfer & w_is_mdu;
`endif

    always_comb begin
        w_alu  = '0;
        w_wben = 1'b1;
        case (i_op)
            c_OP_ADD:  w_alu = i_op1 + w_opb;
            c_OP_SUB:  w_alu = i_op1 - w_opb;
            c_OP_AND:  w_alu = i_op1 & w_opb;
            c_OP_OR:   w_alu = i_op1 | w_opb;
            c_OP_XOR:  w_alu = i_op1 ^ w_opb;
            c_OP_NOR:  w_alu = ~(i_op1 | w_opb);
            c_OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(i_op1) < $signed(w_opb))};
            c_OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (i_op1 < w_opb)};
            c_OP_SLL:  w_alu = w_opb << w_shamt;
            c_OP_SRL:  w_alu = w_opb >> w_shamt;
            c_OP_SRA:  w_alu = $signed(w_opb) >>> w_shamt;
            c_OP_LUI:  w_alu = w_opb << 16;
            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
`ifdef EX_FAST_MUL_EN
                w_alu  = w_fast_prod[DATA_W-1:0];
`endif
                w_wben = 1'b0;
            end
            c_OP_MFHI: w_alu = r_hi;
            c_OP_MFLO: w_alu = r_lo;
            c_OP_MTHI, c_OP_MTLO: begin
                w_alu  = i_op1;
                w_wben = 1'b0;
            end
            default: begin
                w_alu  = i_op1 + w_opb;
                w_wben = 1'b0;
            end
        endcase
    end

    assign w_pc4     = i_pc + 32'd4;
    assign w_zero    = (i_op1 == i_op2);
    assign w_btarget = w_pc4 + {{14{i_imm[15]}}, i_imm[15:0], 2'b00};
    assign w_jtarget = {w_pc4[31:28], i_imm, 2'b00};
    assign w_pcsrc   = i_jump | (i_beq & w_zero) | (i_bne & ~w_zero);
    assign w_nextpc  = i_jump ? w_jtarget : (w_pcsrc ? w_btarget : w_pc4);

    // MDU operands are reduced to magnitudes; signs are restored on commit.
    logic              w_a_neg, w_b_neg;
    logic [DATA_W-1:0] w_a_mag, w_b_mag;
    assign w_a_neg = ~i_op[0] & i_op1[DATA_W-1];
    assign w_b_neg = ~i_op[0] & i_op2[DATA_W-1];
    assign w_a_mag = w_a_neg ? -i_op1 : i_op1;
    assign w_b_mag = w_b_neg ? -i_op2 : i_op2;

    logic [DATA_W:0]     w_mul_sum, w_rem_sh, w_diff;
    logic [2*DATA_W-1:0] w_mul_nxt, w_div_nxt, w_prod_fix;
    logic [DATA_W-1:0]   w_quo, w_rem, w_mdu_hi, w_mdu_lo;
    logic                w_ge;

    assign w_mul_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_prod[DATA_W-1:1]};
    assign w_rem_sh  = {r_prod[2*DATA_W-1:DATA_W], r_prod[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opb};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
    assign w_div_nxt = w_ge ? {w_diff[DATA_W-1:0], r_prod[DATA_W-2:0], 1'b1}
                            : {w_rem_sh[DATA_W-1:0], r_prod[DATA_W-2:0], 1'b0};

    assign w_prod_fix = r_neg_lo ? -r_prod : r_prod;
    assign w_quo      = r_neg_lo ? -r_prod[DATA_W-1:0] : r_prod[DATA_W-1:0];
    assign w_rem      = r_neg_hi ? -r_prod[2*DATA_W-1:DATA_W] : r_prod[2*DATA_W-1:DATA_W];
    assign w_mdu_lo   = r_is_div ? (r_div0 ? '1 : w_quo) : w_prod_fix[DATA_W-1:0];
    assign w_mdu_hi   = r_is_div ? (r_div0 ? r_dividend : w_rem) : w_prod_fix[2*DATA_W-1:DATA_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_mdu_start) w_state_nxt = ST_MDU_BUSY;
            ST_MDU_BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_MDU_DONE;
            ST_MDU_DONE: if (w_out_free) w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_opb      <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div0     <= 1'b0;
        end else if (w_mdu_start) begin
            r_cnt      <= CNT_W'(DATA_W);
            r_prod     <= {{DATA_W{1'b0}}, w_a_mag};
            r_opb      <= w_b_mag;
            r_dividend <= i_op1;
            r_is_div   <= i_op[1];
            r_neg_lo   <= w_a_neg ^ w_b_neg;
            r_neg_hi   <= w_a_neg;
            r_div0     <= (i_op2 == '0);
        end else if (r_state == ST_MDU_BUSY) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_prod <= r_is_div ? w_div_nxt : w_mul_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_mdu_commit) begin
            r_hi <= w_mdu_hi;
            r_lo <= w_mdu_lo;
        end else if (w_xfer) begin
            if (i_op == c_OP_MTHI) r_hi <= i_op1;
            if (i_op == c_OP_MTLO) r_lo <= i_op1;
`ifdef EX_FAST_MUL_EN
            if (w_is_mdu & ~i_op[1]) {r_hi, r_lo} <= w_fast_prod;
`endif
        end
    end

    // An accepted iterative MDU op leaves the output register empty until commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_wben   <= 1'b0;
            o_alures <= '0;
            o_op2    <= '0;
            o_nextpc <= '0;
            o_pcsrc  <= 1'b0;
        end else if (w_xfer) begin
            o_valid  <= ~w_mdu_start;
            o_wben   <= w_wben & ~(i_beq | i_bne);
            o_alures <= w_alu;
            o_op2    <= i_op2;
            o_nextpc <= w_nextpc;
            o_pcsrc  <= w_pcsrc;
        end else if (w_mdu_commit) begin
            o_valid  <= 1'b1;
            o_wben   <= 1'b0;
            o_alures <= w_mdu_lo;
            o_pcsrc  <= 1'b0;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_pipe
// Purpose  : Scoreboard bench for ex_stage_pipe (default build, DATA_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0, o_ready;
    logic [31:0] i_pc = '0;
    logic [25:0] i_imm = '0;
    logic [31:0] i_op1 = '0, i_op2 = '0;
    logic        i_alusrc = 1'b0, i_extop = 1'b0;
    logic [4:0]  i_op = '0;
    logic        i_jump = 1'b0, i_beq = 1'b0, i_bne = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_valid, o_wben, o_pcsrc;
    logic [31:0] o_alures, o_op2, o_nextpc;

    always #5 i_clk = ~i_clk;

    ex_stage_pipe #(.DATA_W(32), .SHAMT_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_imm(i_imm), .i_op1(i_op1), .i_op2(i_op2),
        .i_alusrc(i_alusrc), .i_extop(i_extop), .i_op(i_op),
        .i_jump(i_jump), .i_beq(i_beq), .i_bne(i_bne), .i_ready(i_ready),
        .o_valid(o_valid), .o_wben(o_wben), .o_alures(o_alures),
        .o_op2(o_op2), .o_nextpc(o_nextpc), .o_pcsrc(o_pcsrc)
    );

    // mask bits: [3] result, [2] wben, [1] nextpc/pcsrc, [0] store data
    typedef struct packed {
        logic [31:0] res;
        logic        wben;
        logic [31:0] npc;
        logic        pcsrc;
        logic [31:0] st;
        logic [3:0]  mask;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    exp_t  m_e;
    string m_t;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic wben, input logic [31:0] npc,
                                input logic pcsrc, input logic [31:0] st, input logic [3:0] mask);
        exp_t e;
        e.res = res; e.wben = wben; e.npc = npc; e.pcsrc = pcsrc; e.st = st; e.mask = mask;
        return e;
    endfunction

    function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0]         s;
        logic signed [31:0] sa, sb;
        s = a[4:0]; sa = a; sb = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return b << s;
            5'd9:  return b >> s;
            5'd10: return sb >>> s;
            5'd11: return {b[15:0], 16'h0000};
            default: return a + b;
        endcase
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_output", 32'(exp_q.size()), 32'd1);
            end else begin
                m_e = exp_q.pop_front();
                m_t = tag_q.pop_front();
                if (m_e.mask[3]) check_val({m_t, "_res"}, o_alures, m_e.res);
                if (m_e.mask[2]) check_val({m_t, "_wben"}, {31'd0, o_wben}, {31'd0, m_e.wben});
                if (m_e.mask[1]) begin
                    check_val({m_t, "_nextpc"}, o_nextpc, m_e.npc);
                    check_val({m_t, "_pcsrc"}, {31'd0, o_pcsrc}, {31'd0, m_e.pcsrc});
                end
                if (m_e.mask[0]) check_val({m_t, "_op2"}, o_op2, m_e.st);
            end
        end
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [25:0] imm, input logic alusrc, input logic extop,
                         input logic jmp, input logic beq, input logic bne, input logic [31:0] pc);
        i_op = op; i_op1 = a; i_op2 = b; i_imm = imm; i_alusrc = alusrc; i_extop = extop;
        i_jump = jmp; i_beq = beq; i_bne = bne; i_pc = pc;
    endtask

    // Presents the driven instruction; returns 1 time unit after the accepting edge.
    task automatic send(input exp_t e, input string tag, input bit push);
        int n;
        n = 0;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            n++;
            @(negedge i_clk);
        end
        if (!o_ready) check_val({tag, "_accept_timeout"}, {31'd0, o_ready}, 32'd1);
        if (push) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic wben, input string tag);
        drive(op, a, b, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200);
        send(mk(res, wben, 32'h0000_0204, 1'b0, b, 4'b1111), tag, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(posedge i_clk);
        end
        #1;
        check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          busy;
        logic [4:0]  op;
        logic [31:0] a, b, beff, pc;
        logic [25:0] imm;
        logic        src, ext;
        int          r;

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_val("rst_valid",  {31'd0, o_valid}, 32'd0);
        check_val("rst_wben",   {31'd0, o_wben},  32'd0);
        check_val("rst_alures", o_alures, 32'd0);
        check_val("rst_op2",    o_op2,    32'd0);
        check_val("rst_nextpc", o_nextpc, 32'd0);
        check_val("rst_pcsrc",  {31'd0, o_pcsrc}, 32'd0);
        check_val("rst_ready",  {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;

        alu(5'd0,  32'd7,         32'hFFFF_FFF9, 32'h0000_0000, 1'b1, "add_wrap");
        alu(5'd10, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b1, "sra");
        alu(5'd6,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b1, "slt_neg");
        alu(5'd7,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, "sltu_big");
        alu(5'd25, 32'd3,         32'd4,         32'd7,         1'b0, "op25_add_nowb");

        drive(5'd0, 32'h10, 32'h0, 26'h0FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
        send(mk(32'h0000_000F, 1'b1, 32'h44, 1'b0, 32'h0, 4'b1110), "imm_sext", 1'b1);
        drive(5'd0, 32'h10, 32'h0, 26'h0FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
        send(mk(32'h0001_000F, 1'b1, 32'h44, 1'b0, 32'h0, 4'b1110), "imm_zext", 1'b1);
        drive(5'd11, 32'h0, 32'h0, 26'h01234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
        send(mk(32'h1234_0000, 1'b1, 32'h44, 1'b0, 32'h0, 4'b1110), "lui", 1'b1);

        drive(5'd1, 32'd5, 32'd5, 26'h00003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
        send(mk(32'h0, 1'b0, 32'h110, 1'b1, 32'd5, 4'b1111), "beq_taken", 1'b1);
        drive(5'd1, 32'd5, 32'd6, 26'h00003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
        send(mk(32'hFFFF_FFFF, 1'b0, 32'h104, 1'b0, 32'd6, 4'b1111), "beq_not", 1'b1);
        drive(5'd1, 32'd5, 32'd6, 26'h0FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        send(mk(32'hFFFF_FFFF, 1'b0, 32'h100, 1'b1, 32'd6, 4'b1111), "bne_back", 1'b1);
        drive(5'd0, 32'd0, 32'd0, 26'h00040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
        send(mk(32'h0, 1'b0, 32'h100, 1'b1, 32'd0, 4'b1010), "jump", 1'b1);

        for (int k = 0; k < 24; k++) begin
            r   = $urandom_range(0, 23);
            op  = (r < 12) ? 5'(r) : 5'(r + 8);
            a   = $urandom;
            b   = $urandom;
            imm = 26'($urandom);
            src = 1'($urandom);
            ext = 1'($urandom);
            pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            beff = !src ? b : (ext ? {{16{imm[15]}}, imm[15:0]} : {16'h0, imm[15:0]});
            drive(op, a, b, imm, src, ext, 1'b0, 1'b0, 1'b0, pc);
            send(mk(model_alu(op, a, beff), (op < 5'd12), pc + 32'd4, 1'b0, b, 4'b1111),
                 $sformatf("rand%0d_op%0d", k, op), 1'b1);
        end
        drain("alu");

        drive(5'd12, 32'hFFFF_FFFE, 32'd3, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'hFFFF_FFFA, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100), "mult", 1'b1);
        busy = 0;
        @(negedge i_clk);
        while (!o_ready && busy < 200) begin
            busy++;
            @(negedge i_clk);
        end
        check_val("mult_busy_cycles", 32'(busy), 32'd33);
        @(posedge i_clk); #1;
        alu(5'd16, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, "mult_mfhi");
        alu(5'd17, 32'd0, 32'd0, 32'hFFFF_FFFA, 1'b1, "mult_mflo");

        drive(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'h0000_0001, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100), "multu", 1'b1);
        alu(5'd16, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1, "multu_mfhi");

        drive(5'd14, 32'hFFFF_FFF9, 32'd2, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'hFFFF_FFFD, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100), "div_m7_2", 1'b1);
        alu(5'd16, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_m7_2_hi");
        drive(5'd14, 32'd7, 32'hFFFF_FFFE, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'hFFFF_FFFD, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100), "div_7_m2", 1'b1);
        alu(5'd16, 32'd0, 32'd0, 32'h0000_0001, 1'b1, "div_7_m2_hi");
        drive(5'd15, 32'd5, 32'd0, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100), "divu_by0", 1'b1);
        alu(5'd16, 32'd0, 32'd0, 32'd5, 1'b1, "divu_by0_hi");
        drive(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100), "div_min_m1", 1'b1);
        alu(5'd16, 32'd0, 32'd0, 32'd0, 1'b1, "div_min_m1_hi");

        alu(5'd18, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, "mthi");
        alu(5'd16, 32'd0, 32'd0, 32'h0000_1234, 1'b1, "mthi_mfhi");
        alu(5'd19, 32'hCAFE_0000, 32'd0, 32'hCAFE_0000, 1'b0, "mtlo");
        alu(5'd17, 32'd0, 32'd0, 32'hCAFE_0000, 1'b1, "mtlo_mflo");
        drain("mdu");

        i_ready = 1'b0;
        alu(5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b1, "stall_a");
        drive(5'd3, 32'h0000_00A0, 32'h0000_000B, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200);
        fork
            send(mk(32'h0000_00AB, 1'b1, 32'h204, 1'b0, 32'hB, 4'b1111), "stall_b", 1'b1);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge i_clk);
                    check_val($sformatf("stall%0d_valid", c), {31'd0, o_valid}, 32'd1);
                    check_val($sformatf("stall%0d_res", c), o_alures, 32'hFF00_FF00);
                    check_val($sformatf("stall%0d_ready", c), {31'd0, o_ready}, 32'd0);
                end
                @(posedge i_clk);
                #1 i_ready = 1'b1;
                @(negedge i_clk);
                check_val("stall_release_ready", {31'd0, o_ready}, 32'd1);
            end
        join
        drain("stall");

        drive(5'd14, 32'd100, 32'd7, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(mk(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0000), "div_abort", 1'b0);
        repeat (5) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check_val("midrst_valid", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_val("midrst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        alu(5'd17, 32'd0, 32'd0, 32'd0, 1'b1, "midrst_mflo");
        alu(5'd16, 32'd0, 32'd0, 32'd0, 1'b1, "midrst_mfhi");
        drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle execute stage.
- Registers its outputs in an EX/MEM register with a valid/ready handshake.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers, and resolves branch/jump targets into the registered output.
- Sits between decode (upstream) and memory stage (downstream).

Parameters:
DATA_W, 32, datapath width (legal 32 or 64); PC is fixed at 32 bits.
SHAMT_W, 5, shift-amount width (5 for DATA_W=32, 6 for 64).

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  upstream presents an instruction.
o_ready  out  1  stage can accept; combinational from FSM state and i_ready.
i_pc  in  32  PC of the instruction.
i_imm  in  26  instruction bits [25:0].
i_op1  in  DATA_W  Rs operand.
i_op2  in  DATA_W  Rt operand.
i_alusrc  in  1  1 selects extended imm as operand 2.
i_extop  in  1  1 sign-extends imm[15:0]; 0 zero-extends.
i_op  in  5  operation code (see Behaviour).
i_jump, i_beq, i_bne  in  1 each  control-flow qualifiers.
i_ready  in  1  downstream can take the output register.
o_valid  out  1  output register holds a result.
o_wben  out  1  result must be written back (0 for MULT/DIV/MTHI/MTLO/branches).
o_alures  out  DATA_W  result.
o_op2  out  DATA_W  registered i_op2 (store data).
o_nextpc  out  32  resolved target.
o_pcsrc  out  1  1 means redirect PC to o_nextpc.

Behaviour:
- Operand 2 = i_alusrc ? ext(imm[15:0]) : i_op2.
- Shift amount = i_op1[SHAMT_W-1:0]; the shifted value is operand 2.
- i_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA, 11 LUI (operand2 << 16).
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
  - 16 MFHI, 17 MFLO, 18 MTHI, 19 MTLO.
  - 20-31 behave as ADD with o_wben=0.
- All arithmetic wraps mod 2^DATA_W; no overflow trap.
- Handshake: transfer when i_valid & o_ready. o_ready = (state==RUN) & (~o_valid | i_ready). Output register loads on transfer; it clears o_valid when i_ready & o_valid and no transfer occurs. Outputs stay stable while o_valid & ~i_ready.
- Latency: ALU/MF/MT/branch ops, accept at cycle N -> o_valid at N+1; back-to-back throughput is 1/cycle.
- Branch: zero = (i_op1 == i_op2).
  - o_pcsrc = i_jump | (i_beq & zero) | (i_bne & ~zero).
  - Jump target = {pc4[31:28], imm, 2'b00}, where pc4 = i_pc+4.
  - Branch target = pc4 + (sext(imm[15:0]) << 2).
  - Not-taken: o_nextpc = pc4, o_pcsrc = 0.
- FSM states: RUN, MDU_BUSY, MDU_DONE.
  - RUN -> MDU_BUSY on accepted op 12-15; operands latched; counter = DATA_W.
  - MDU_BUSY: one iteration per cycle (shift-add multiply, restoring divide on magnitudes); counter decrements; -> MDU_DONE when counter reaches 1 -> 0.
  - MDU_DONE: write HI/LO; load output register (o_valid=1, o_wben=0, o_alures=LO); -> RUN. This requires the output register free; otherwise stay in MDU_DONE.
  - o_ready=0 in MDU_BUSY and MDU_DONE.
  - MDU op latency: accept at N -> o_valid at N+DATA_W+1.
- Multiply: {HI,LO} = 2*DATA_W product; MULT signed, MULTU unsigned.
- Divide: LO = quotient, HI = remainder. Signed DIV truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend.
  - MIN / -1: LO = MIN, HI = 0.
- MTHI/MTLO: write i_op1 into HI/LO at the accept edge; an MFHI accepted next cycle sees the new value.
- Reset: state=RUN, counter=0, HI=LO=0. All registered outputs = 0 (o_valid, o_wben, o_alures, o_op2, o_nextpc, o_pcsrc). o_ready=1 the cycle after reset deasserts if i_ready=1. Reset during MDU_BUSY aborts the operation; HI/LO are not updated.

Optional Feature:
EX_FAST_MUL_EN.
- Defined: MULT/MULTU complete combinationally. HI/LO write at the accept edge; o_valid at N+1; no stall. DIV stays iterative.
- Undefined: MULT/MULTU use the iterative DATA_W-cycle path above.

Test Plan:
- ADD op1=7, op2=0xFFFFFFF9, i_ready=1 -> next cycle o_valid=1, o_alures=0, o_wben=1; SRA op2=0x80000000, shamt=4 -> 0xF8000000.
- BEQ pc=0x100, op1=op2=5, imm=0x0003 -> o_pcsrc=1, o_nextpc=0x110; op2=6 -> o_pcsrc=0, o_nextpc=0x104; jump imm=0x40 -> o_nextpc=0x100.
- MULT 0xFFFFFFFE x 3 -> o_ready low 33 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- i_ready held 0 for 3 cycles with o_valid=1 -> outputs frozen, o_ready=0, no input accepted; release -> next op accepted that cycle.
- Assert i_rst mid-DIV, then MFLO -> 0, o_valid=0 during reset, state back to RUN.
